viterbi_err_channel: RTL

//  Parametrised noisy-channel model between convolutional encoder and Viterbi decoder.

---
 rtl/viterbi_err_channel.sv | 126 ++++++++++++
 1 files changed

// File: rtl/viterbi_err_channel.sv
// Noisy-channel model: registers encoder symbols, flips masked bits (periodic/burst/random).
// Define VITERBI_CHAN_STATS_EN to build the injection/symbol counters.
module viterbi_err_channel #(
    parameter int                W      = 2,
    parameter int                N      = 3,
    parameter int                BURST  = 4,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  logic [W-1:0] sym_i,
    input  logic [1:0]   mode_i,
    input  logic [W-1:0] mask_i,
    input  logic [7:0]   thresh_i,
    input  logic         clr_i,
    output logic         valid_o,
    output logic [W-1:0] sym_o,
    output logic [W-1:0] err_o,
    output logic [15:0]  inj_ct_o,
    output logic [15:0]  sym_ct_o
);

    localparam int RW = (BURST > 1) ? $clog2(BURST + 1) : 1;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [N-1:0]      idx_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic              trigger;
    logic              inject;
    logic [W-1:0]      flip;

    assign trigger = valid_i && (idx_q == '1);
    assign flip    = inject ? mask_i : '0;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        inject  = 1'b0;
        case (mode_i)
            2'd1: inject = trigger;
            2'd2: begin
                if (state_q == S_BURST) begin
                    if (valid_i) begin
                        inject = 1'b1;
                        rem_d  = rem_q - RW'(1);
                        if (rem_q == RW'(1))
                            state_d = S_IDLE;
                    end
                end else if (trigger) begin
                    inject = 1'b1;
                    if (BURST > 1) begin
                        state_d = S_BURST;
                        rem_d   = RW'(BURST - 1);
                    end
                end
            end
            2'd3: inject = valid_i && (lfsr_q[7:0] < thresh_i);
            default: inject = 1'b0;
        endcase
        // leaving burst mode or clearing aborts any burst in flight
        if (mode_i != 2'd2 || clr_i) begin
            state_d = S_IDLE;
            rem_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            lfsr_q  <= SEED;
            valid_o <= 1'b0;
            sym_o   <= '0;
            err_o   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            valid_o <= valid_i;
            if (clr_i)
                idx_q <= '0;
            else if (valid_i)
                idx_q <= idx_q + 1'b1;
            if (valid_i) begin
                lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
                sym_o  <= sym_i ^ flip;
                err_o  <= flip;
            end
        end
    end

`ifdef VITERBI_CHAN_STATS_EN
    logic [15:0] inj_ct_q, sym_ct_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_ct_q <= '0;
            sym_ct_q <= '0;
        end else if (clr_i) begin
            inj_ct_q <= '0;
            sym_ct_q <= '0;
        end else begin
            if (valid_i && sym_ct_q != 16'hFFFF)
                sym_ct_q <= sym_ct_q + 16'd1;
            if (inject && inj_ct_q != 16'hFFFF)
                inj_ct_q <= inj_ct_q + 16'd1;
        end
    end

    assign inj_ct_o = inj_ct_q;
    assign sym_ct_o = sym_ct_q;
`else
    assign inj_ct_o = 16'h0;
    assign sym_ct_o = 16'h0;
`endif

endmodule
